// File: rtl/pipeline_perf_monitor.sv
// Multi-channel hazard event and cycle counter with a bounded counting window.
// Shadow registers give software a coherent snapshot without disturbing live counts.
module pipeline_perf_monitor #(
  parameter int unsigned NUM_EVT = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SEL_W   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [CNT_W-1:0]   cycle_limit_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT-1:0] ovf_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [CNT_W-1:0]   cnt_q    [NUM_EVT];
  logic [CNT_W-1:0]   cnt_d    [NUM_EVT];
  logic [CNT_W-1:0]   shadow_q [NUM_EVT];
  logic [CNT_W-1:0]   cycle_d;
  logic [NUM_EVT-1:0] ovf_d;
  logic [CNT_W-1:0]   rd_mux_c;
  logic               counted_c;
  logic               done_d;

  // Next-state, counter update and clear override
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_o;
    cnt_d     = cnt_q;
    ovf_d     = ovf_o;
    counted_c = (state_q == ST_RUN) && start_i;

    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        // A saturated cycle counter can never reach the limit, so it keeps running
        if (start_i && (cycle_limit_i != '0) && (cycle_o != CNT_MAX) &&
            ((cycle_o + CNT_W'(1)) == cycle_limit_i))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (counted_c) begin
      if (cycle_o != CNT_MAX) cycle_d = cycle_o + CNT_W'(1);
      for (int k = 0; k < int'(NUM_EVT); k++) begin
        if (evt_i[k]) begin
          if (cnt_q[k] == CNT_MAX) ovf_d[k] = 1'b1;
          else                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end

    if (clear_i) begin
      state_d = ST_IDLE;
      cycle_d = '0;
      cnt_d   = '{default: '0};
      ovf_d   = '0;
    end

    done_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  // Shadow readout mux; selects beyond the channel count read zero
  always_comb begin
    rd_mux_c = '0;
    for (int k = 0; k < int'(NUM_EVT); k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux_c = shadow_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q     <= '{default: '0};
      shadow_q  <= '{default: '0};
      cycle_o   <= '0;
      ovf_o     <= '0;
      rd_data_o <= '0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cycle_o   <= cycle_d;
      ovf_o     <= ovf_d;
      running_o <= (state_d == ST_RUN);
      done_o    <= done_d;
      rd_data_o <= rd_mux_c;
      // Snapshot takes pre-edge counts, so it also survives a simultaneous clear
      if (snap_i) shadow_q <= cnt_q;
    end
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench for pipeline_perf_monitor (3 channels, 8-bit counters).
// Readout expectations flow through a scoreboard queue.
module tb_pipeline_perf_monitor;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic       clear_i;
  logic [2:0] evt_i;
  logic [7:0] cycle_limit_i;
  logic       snap_i;
  logic [1:0] rd_sel_i;
  logic [7:0] rd_data_o;
  logic [7:0] cycle_o;
  logic       running_o;
  logic       done_o;
  logic [2:0] ovf_o;

  int errors = 0;
  int checks = 0;
  int done_cnt;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  pipeline_perf_monitor #(.NUM_EVT(3), .CNT_W(8), .SEL_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .evt_i(evt_i), .cycle_limit_i(cycle_limit_i), .snap_i(snap_i),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o), .cycle_o(cycle_o),
    .running_o(running_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    rd_sel_i = sel;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    check(tag_q.pop_front(), 32'(rd_data_o), 32'(exp_q.pop_front()));
  endtask

  task automatic do_snap();
    snap_i = 1'b1;
    tick();
    snap_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; start_i = 1'b0; clear_i = 1'b0; evt_i = '0;
    cycle_limit_i = '0; snap_i = 1'b0; rd_sel_i = '0;
    tick(); tick();
    check("rst_running", 32'(running_o), 0);
    check("rst_done",    32'(done_o),    0);
    check("rst_cycle",   32'(cycle_o),   0);
    check("rst_ovf",     32'(ovf_o),     0);
    check("rst_rdata",   32'(rd_data_o), 0);
    rst_i = 1'b1;

    // Basic window, limit 30
    cycle_limit_i = 8'd30;
    start_i = 1'b1;
    tick();
    check("start_running", 32'(running_o), 1);
    check("start_cycle",   32'(cycle_o),   0);
    done_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      evt_i = {1'b0, c == 10, (c >= 3) && (c <= 5)};
      tick();
      if (done_o) done_cnt++;
      if (c == 29) begin
        check("win_cycle29", 32'(cycle_o), 29);
        check("win_done29",  32'(done_o),  0);
      end
    end
    check("win_cycle30", 32'(cycle_o),   30);
    check("win_done30",  32'(done_o),    1);
    check("win_stopped", 32'(running_o), 0);
    evt_i = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o) done_cnt++;
    end
    check("done_pulses",  32'(done_cnt), 1);
    check("done_frozen",  32'(cycle_o),  30);
    check("win_ovf",      32'(ovf_o),    0);
    evt_i = '0; start_i = 1'b0;
    do_snap();
    read_chk("win_ch0", 2'd0, 8'd3);
    read_chk("win_ch1", 2'd1, 8'd1);
    read_chk("win_ch2", 2'd2, 8'd0);

    // Saturation, unlimited window
    do_clear();
    check("clr_running", 32'(running_o), 0);
    check("clr_cycle",   32'(cycle_o),   0);
    cycle_limit_i = '0;
    start_i = 1'b1;
    tick();
    evt_i = 3'b001;
    repeat (255) tick();
    check("sat_ovf_255",   32'(ovf_o),   0);
    check("sat_cycle_255", 32'(cycle_o), 255);
    tick();
    check("sat_ovf_256", 32'(ovf_o), 1);
    repeat (44) tick();
    check("sat_ovf_300",   32'(ovf_o),     1);
    check("sat_cycle_300", 32'(cycle_o),   255);
    check("sat_running",   32'(running_o), 1);
    do_snap();
    evt_i = '0;
    read_chk("sat_ch0",    2'd0, 8'd255);
    read_chk("sat_ch1",    2'd1, 8'd0);
    read_chk("sel_oor",    2'd3, 8'd0);

    // Pause with events present
    start_i = 1'b0;
    do_clear();
    start_i = 1'b1;
    tick();
    evt_i = 3'b001;
    repeat (10) tick();
    check("pre_pause_cycle", 32'(cycle_o), 10);
    start_i = 1'b0;
    repeat (3) tick();
    check("pause_mid_cycle", 32'(cycle_o),   10);
    check("pause_mid_run",   32'(running_o), 1);
    repeat (2) tick();
    check("pause_end_cycle", 32'(cycle_o),   10);
    check("pause_end_run",   32'(running_o), 1);
    do_snap();
    evt_i = '0;
    read_chk("pause_ch0", 2'd0, 8'd10);

    // Clear and snap on the same edge
    do_clear();
    start_i = 1'b1;
    tick();
    evt_i = 3'b001;
    repeat (7) tick();
    evt_i = '0; start_i = 1'b0;
    clear_i = 1'b1; snap_i = 1'b1;
    tick();
    clear_i = 1'b0; snap_i = 1'b0;
    check("cs_running", 32'(running_o), 0);
    check("cs_cycle",   32'(cycle_o),   0);
    read_chk("cs_shadow0", 2'd0, 8'd7);
    do_snap();
    read_chk("cs_live0", 2'd0, 8'd0);

    // Reset mid-run with cnt0=12, shadow0=5
    do_clear();
    start_i = 1'b1;
    tick();
    evt_i = 3'b001;
    repeat (5) tick();
    do_snap();
    repeat (6) tick();
    evt_i = '0;
    check("pre_rst_cycle", 32'(cycle_o), 12);
    read_chk("pre_rst_shadow0", 2'd0, 8'd5);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1; start_i = 1'b0;
    check("mrst_running", 32'(running_o), 0);
    check("mrst_done",    32'(done_o),    0);
    check("mrst_cycle",   32'(cycle_o),   0);
    check("mrst_ovf",     32'(ovf_o),     0);
    check("mrst_rdata",   32'(rd_data_o), 0);
    read_chk("mrst_shadow0", 2'd0, 8'd0);
    do_snap();
    read_chk("mrst_live0", 2'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
